// File: rtl/rom_read_arbiter.sv
// Two-requester arbiter/sequencer for a one-cycle-latency synchronous ROM; 3-cycle accept-to-response.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build is fixed priority (port 0 wins).
module rom_read_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_address,
  output logic                     req0_ready,
  output logic                     resp0_valid,
  output logic [DATA_WIDTH-1:0]    resp0_data,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_address,
  output logic                     req1_ready,
  output logic                     resp1_valid,
  output logic [DATA_WIDTH-1:0]    resp1_data,
  output logic                     rom_read_enable,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]    rom_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t                   r_state;
  logic                     r_grant1;
  logic                     r_rom_read_enable;
  logic [ADDRESS_WIDTH-1:0] r_rom_address;
  logic                     r_resp0_valid;
  logic                     r_resp1_valid;
  logic [DATA_WIDTH-1:0]    r_resp0_data;
  logic [DATA_WIDTH-1:0]    r_resp1_data;
  logic                     w_grant1;
  logic                     w_handshake;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic r_last1;
  // On a tie, port 1 wins only if port 0 was granted last.
  assign w_grant1 = req1_valid && (!req0_valid || !r_last1);
`else
  assign w_grant1 = req1_valid && !req0_valid;
`endif

  assign req0_ready  = reset_n && (r_state == IDLE) && req0_valid && !w_grant1;
  assign req1_ready  = reset_n && (r_state == IDLE) && w_grant1;
  assign w_handshake = req0_ready || req1_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state           <= IDLE;
      r_grant1          <= 1'b0;
      r_rom_read_enable <= 1'b0;
      r_rom_address     <= '0;
      r_resp0_valid     <= 1'b0;
      r_resp1_valid     <= 1'b0;
      r_resp0_data      <= '0;
      r_resp1_data      <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      r_last1           <= 1'b1;
`endif
    end else begin
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_handshake) begin
            r_grant1          <= w_grant1;
            r_rom_address     <= w_grant1 ? req1_address : req0_address;
            r_rom_read_enable <= 1'b1;
            r_state           <= ISSUE;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            r_last1           <= w_grant1;
`endif
          end
        end
        ISSUE: begin
          r_rom_read_enable <= 1'b0;
          r_state           <= CAPTURE;
        end
        CAPTURE: begin
          // Only the granted port's data register moves.
          if (r_grant1) begin
            r_resp1_data  <= rom_data;
            r_resp1_valid <= 1'b1;
          end else begin
            r_resp0_data  <= rom_data;
            r_resp0_valid <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rom_read_enable = r_rom_read_enable;
  assign rom_address     = r_rom_address;
  assign resp0_valid     = r_resp0_valid;
  assign resp1_valid     = r_resp1_valid;
  assign resp0_data      = r_resp0_data;
  assign resp1_data      = r_resp1_data;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus random traffic against a cycle-count reference model.
// Honours ROM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_rom_read_arbiter;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_address, req1_address;
  logic       req0_ready, req1_ready;
  logic       resp0_valid, resp1_valid;
  logic [7:0] resp0_data, resp1_data;
  logic       rom_read_enable;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic [7:0] rom_mem [256];

  always #5 clock = ~clock;

  always @(posedge clock) if (rom_read_enable) rom_data <= rom_mem[rom_address];

  rom_read_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_address(req0_address), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_address(req1_address), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .rom_read_enable(rom_read_enable), .rom_address(rom_address), .rom_data(rom_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: busy counts cycles left before the arbiter can grant again.
  int         m_busy = 0;
  bit         m_last = 1'b1;
  bit         m_g    = 1'b0;
  logic [7:0] m_addr = 8'h00;
  bit         m_rv0  = 1'b0, m_rv1 = 1'b0;
  logic [7:0] m_rd0  = 8'h00, m_rd1 = 8'h00;
  bit         hs0, hs1;
  bit         glog [$];
  logic [7:0] r0log [$];
  logic [7:0] r1log [$];

  // Check the current cycle (inputs already driven), advance the model, move to the next negedge.
  task automatic cycle();
    bit w1, e0, e1;
    #1;
    w1 = req1_valid && (!req0_valid || (RR && !m_last));
    e1 = reset_n && (m_busy == 0) && w1;
    e0 = reset_n && (m_busy == 0) && req0_valid && !w1;
    check_val("req0_ready", 32'(req0_ready), 32'(e0));
    check_val("req1_ready", 32'(req1_ready), 32'(e1));
    check_val("rom_re", 32'(rom_read_enable), 32'(m_busy == 2));
    check_val("rom_addr", 32'(rom_address), 32'(m_addr));
    check_val("resp0_valid", 32'(resp0_valid), 32'(m_rv0));
    check_val("resp1_valid", 32'(resp1_valid), 32'(m_rv1));
    check_val("resp0_data", 32'(resp0_data), 32'(m_rd0));
    check_val("resp1_data", 32'(resp1_data), 32'(m_rd1));
    if (resp0_valid) r0log.push_back(resp0_data);
    if (resp1_valid) r1log.push_back(resp1_data);
    hs0 = e0;
    hs1 = e1;
    if (!reset_n) begin
      m_busy = 0; m_last = 1'b1; m_addr = 8'h00;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 8'h00; m_rd1 = 8'h00;
    end else begin
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      if (m_busy == 1) begin
        if (m_g) begin m_rv1 = 1'b1; m_rd1 = rom_mem[m_addr]; end
        else     begin m_rv0 = 1'b1; m_rd0 = rom_mem[m_addr]; end
      end
      if (m_busy > 0) m_busy--;
      else if (e0 || e1) begin
        m_busy = 2;
        m_g    = e1;
        m_addr = e1 ? req1_address : req0_address;
        m_last = e1;
        glog.push_back(e1);
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    rom_mem[8'h05] = 8'hA7; rom_mem[8'h01] = 8'h11; rom_mem[8'h02] = 8'h22;
    rom_mem[8'h10] = 8'h3C; rom_mem[8'h11] = 8'h3D; rom_mem[8'h12] = 8'h3E;
    reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_address = 8'h00; req1_address = 8'h00;
    @(negedge clock);
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single read on port 0.
    reset_n = 1'b1; req0_valid = 1'b1; req0_address = 8'h05;
    cycle();
    req0_valid = 1'b0;
    #1 check_val("single_re_issue", 32'(rom_read_enable), 32'd1);
    check_val("single_addr", 32'(rom_address), 32'h05);
    cycle();
    #1 check_val("single_re_capture", 32'(rom_read_enable), 32'd0);
    cycle();
    #1 check_val("single_resp0_valid", 32'(resp0_valid), 32'd1);
    check_val("single_resp0_data", 32'(resp0_data), 32'hA7);
    check_val("single_resp1_valid", 32'(resp1_valid), 32'd0);
    cycle();

    // Both requesters held from reset.
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
    glog.delete(); r0log.delete(); r1log.delete();
    req0_valid = 1'b1; req0_address = 8'h01; req1_valid = 1'b1; req1_address = 8'h02;
    repeat (12) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) cycle();
    check_val("tie_grants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < glog.size(); i++)
      check_val($sformatf("tie_grant%0d", i), 32'(glog[i]), RR ? 32'(i % 2) : 32'd0);
    check_val("tie_resp0_count", 32'(r0log.size()), RR ? 32'd2 : 32'd4);
    check_val("tie_resp1_count", 32'(r1log.size()), RR ? 32'd2 : 32'd0);
    if (r0log.size() > 0) check_val("tie_resp0_data", 32'(r0log[0]), 32'h11);
    if (r1log.size() > 0) check_val("tie_resp1_data", 32'(r1log[0]), 32'h22);

    // Back-to-back reads on port 1.
    r1log.delete();
    n = 0;
    req1_valid = 1'b1; req1_address = 8'h10;
    for (int i = 0; i < 20 && n < 3; i++) begin
      cycle();
      if (hs1) begin
        n++;
        if (n == 3) req1_valid = 1'b0;
        else req1_address = 8'(8'h10 + n);
      end
    end
    req1_valid = 1'b0;
    repeat (4) cycle();
    check_val("b2b_count", 32'(r1log.size()), 32'd3);
    for (int i = 0; i < 3 && i < r1log.size(); i++)
      check_val($sformatf("b2b_data%0d", i), 32'(r1log[i]), 32'(8'h3C + i));

    // Reset while a port-0 read is in CAPTURE.
    r0log.delete();
    req0_valid = 1'b1; req0_address = 8'h05;
    cycle();
    req0_valid = 1'b0;
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    #1 check_val("rst_re", 32'(rom_read_enable), 32'd0);
    check_val("rst_addr", 32'(rom_address), 32'd0);
    check_val("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    check_val("rst_resp0_data", 32'(resp0_data), 32'd0);
    check_val("rst_resp1_data", 32'(resp1_data), 32'd0);
    repeat (2) cycle();
    check_val("rst_dropped", 32'(r0log.size()), 32'd0);
    req0_valid = 1'b1; req0_address = 8'h01;
    cycle();
    req0_valid = 1'b0;
    repeat (4) cycle();
    check_val("rst_after_count", 32'(r0log.size()), 32'd1);
    if (r0log.size() > 0) check_val("rst_after_data", 32'(r0log[0]), 32'h11);

    // Port 1 address moves while port 0 is in flight.
    req0_valid = 1'b1; req0_address = 8'h30;
    cycle();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_address = 8'h40;
    cycle();
    req1_address = 8'h41;
    #1 check_val("stab_addr_capture", 32'(rom_address), 32'h30);
    cycle();
    cycle();
    req1_valid = 1'b0;
    #1 check_val("stab_addr_new", 32'(rom_address), 32'h41);
    repeat (3) cycle();

    // Random traffic obeying the hold-until-handshake rule.
    hs0 = 1'b0; hs1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      if (!req0_valid || hs0) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_address = 8'($urandom);
      end
      if (!req1_valid || hs1) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_address = 8'($urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Two-port arbiter and sequencer for a single synchronous, one-cycle-latency ROM. The arbiter accepts read requests from two requesters over a valid/ready handshake and drives the ROM's `read_enable` and `address`. It captures the ROM's `data` and returns it to the winning requester as a one-cycle response pulse. It sits between the fetch/load units and the shared program/constant ROM instance.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 8: width of request and ROM addresses.
- `DATA_WIDTH`, default 8: width of ROM words and response data.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `req0_valid` in 1: requester 0 has a read pending.
- `req0_address` in `ADDRESS_WIDTH`: requester 0 read address.
- `req0_ready` out 1: arbiter accepts requester 0 this cycle.
- `resp0_valid` out 1: one-cycle pulse, `resp0_data` valid.
- `resp0_data` out `DATA_WIDTH`: read data for requester 0.
- `req1_valid`, `req1_address`, `req1_ready`, `resp1_valid`, `resp1_data`: same as port 0, for requester 1.
- `rom_read_enable` out 1: to ROM `read_enable`.
- `rom_address` out `ADDRESS_WIDTH`: to ROM `address`.
- `rom_data` in `DATA_WIDTH`: from ROM `data`, valid the cycle after an enabled edge.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - If any `reqN_valid` is set, grant one requester. Its `reqN_ready` is driven combinationally high this cycle; the other ready stays low.
  - Handshake occurs when `valid && ready` at the rising edge. On the handshake, latch the address into `rom_address`, latch the grant index, and move to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE: `rom_read_enable` = 1, `rom_address` held. The ROM samples on this edge. Go to CAPTURE.
- CAPTURE: `rom_read_enable` = 0. Register `rom_data` into `respG_data` for the granted port G. Set `respG_valid` for the next cycle. Go to IDLE.
- `resp_valid` is high for exactly one cycle and coincides with IDLE, so a new grant may occur in that same cycle.
- Responses have no back-pressure; the requester must consume the pulse.
- `respN_data` holds its last value until the next response to that port. The non-granted port's data register is unchanged.
- Both ready signals are 0 in ISSUE and CAPTURE.
- Requester rule: once `reqN_valid` is raised, `reqN_valid` and `reqN_address` stay stable until the handshake. The arbiter does not check this.
- `rom_address` changes only on a handshake edge; it is stable during ISSUE and CAPTURE.
- Arbitration: see Configuration. A lone request is always granted in IDLE.
- Reset (`reset_n` = 0 at an edge), from any state including mid-transaction:
  - state goes to IDLE;
  - the in-flight read is dropped and no response is issued;
  - `rom_read_enable` = 0, `rom_address` = 0;
  - all resp_valid = 0, all resp_data = 0;
  - grant history set to "port 1 last".

## Timing
- All outputs reset to 0. The `reqN_ready` signals are also 0 during reset, because ready is gated by `reset_n`.
- Handshake at edge T, cycle by cycle:
  - cycle T+1: ISSUE, `rom_read_enable` = 1;
  - cycle T+2: CAPTURE, `rom_data` valid;
  - cycle T+3: `respG_valid` = 1 with data.
- Latency is 3 cycles from the accept edge to the response pulse.
- Throughput: at most one read per 3 cycles. Back-to-back grants occur at T, T+3, T+6, ...
- `rom_read_enable` and `rom_address` are registered. `reqN_ready` is combinational from state, valids and grant history.

## Configuration
- `ROM_ARB_ROUND_ROBIN_EN` defined:
  - when both requests are pending in IDLE, grant the port not granted last;
  - the grant history updates on every handshake;
  - after reset, port 0 wins the first tie.
- Not defined: fixed priority, port 0 always wins ties. The grant-history register is not built.

## Test plan
- Reset then single read: ROM[0x05] = 0xA7, req0 address 0x05 accepted at T → `rom_read_enable` high only in T+1, `rom_address` = 0x05, `resp0_valid` pulse at T+3 with 0xA7, `resp1_valid` stays 0.
- Simultaneous requests, both held (req0 at 0x01 → 0x11, req1 at 0x02 → 0x22):
  - round-robin build: grants alternate 0,1,0,1 at T, T+3, T+6, T+9;
  - fixed-priority build: port 0 is granted every 3 cycles and port 1 is never granted until req0 drops.
- Back-to-back on port 1 (addresses 0x10, 0x11, 0x12 → 0x3C, 0x3D, 0x3E): `resp1_valid` pulses at T+3, T+6, T+9 with the correct words; `req1_ready` high only in IDLE cycles.
- `reset_n` low during CAPTURE of a req0 read → no `resp0_valid` pulse; state IDLE; all outputs 0 the cycle after release; a new request completes normally.
- Address stability: change `req1_address` while port 0 is in ISSUE/CAPTURE → `rom_address` unchanged until port 1's handshake edge.
